// File: rtl/npu_act_pkg.sv
// Shared types and constants for the NPU activation stage.
//   act_mode_t  : per-beat activation select carried down the pipeline
//   ACT_CNT_W   : width of the optional statistics counters
//   cnt_sat_add : counter add that sticks at all-ones instead of wrapping
package npu_act_pkg;

    typedef enum logic [1:0] {
        ACT_IDENT,
        ACT_RELU,
        ACT_LEAKY,
        ACT_CLIP
    } act_mode_t;

    localparam int unsigned ACT_CNT_W = 16;

    // Saturating counter increment; carry-out means the counter is full.
    function automatic logic [ACT_CNT_W-1:0] cnt_sat_add(
        input logic [ACT_CNT_W-1:0] cnt,
        input logic [ACT_CNT_W-1:0] inc
    );
        logic [ACT_CNT_W:0] sum;
        sum = {1'b0, cnt} + {1'b0, inc};
        return sum[ACT_CNT_W] ? '1 : sum[ACT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/act_lane.sv
// One lane of the activation stage: activation followed by rounding right
// shift and saturation to OUT_W bits. Purely combinational.
// Optional feature macro: ACT_STATS_EN (adds per-lane zero/sat flags).
// Ports:
//   x         in  DATA_W  signed lane value
//   mode      in  2       activation select
//   clip_max  in  DATA_W  signed clipped-ReLU upper bound
//   r         out OUT_W   requantised, saturated result
//   zero_flag out 1       negative input forced to 0 by ReLU/clip (ACT_STATS_EN)
//   sat_flag  out 1       clamped by clip_max or requant saturation (ACT_STATS_EN)
module act_lane
    import npu_act_pkg::*;
#(
    parameter int unsigned DATA_W      = 22,
    parameter int unsigned OUT_W       = 22,
    parameter int unsigned SHIFT       = 0,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic signed [DATA_W-1:0] x,
    input  act_mode_t                mode,
    input  logic signed [DATA_W-1:0] clip_max,
    output logic        [OUT_W-1:0]  r
`ifdef ACT_STATS_EN
    ,
    output logic                     zero_flag,
    output logic                     sat_flag
`endif
);

    // One extra bit so the rounding add cannot overflow.
    localparam int unsigned EXT_W   = DATA_W + 1;
    localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EXT_W-1:0] RND =
        (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : '0;
    localparam logic signed [EXT_W-1:0] OUT_MAX =
        {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] OUT_MIN =
        {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                     neg;
    logic signed [DATA_W-1:0] y;
    logic signed [EXT_W-1:0]  y_ext;
    logic signed [EXT_W-1:0]  rounded;
    logic signed [EXT_W-1:0]  shifted;
    logic                     sat_hi;
    logic                     sat_lo;

    assign neg = x[DATA_W-1];

    // Activation function.
    always_comb begin
        y = x;
        case (mode)
            ACT_IDENT: y = x;
            ACT_RELU:  y = neg ? '0 : x;
            ACT_LEAKY: y = neg ? (x >>> LEAKY_SHIFT) : x;
            ACT_CLIP: begin
                if (neg) begin
                    y = '0;
                end else if (x > clip_max) begin
                    // A negative bound still floors the result at zero.
                    y = clip_max[DATA_W-1] ? '0 : clip_max;
                end
            end
            default:   y = x;
        endcase
    end

    // Round-half-up right shift, then saturate to the output range.
    always_comb begin
        y_ext   = {y[DATA_W-1], y};
        rounded = y_ext + RND;
        shifted = rounded >>> SHIFT;
        sat_hi  = shifted > OUT_MAX;
        sat_lo  = shifted < OUT_MIN;
        r       = shifted[OUT_W-1:0];
        if (sat_hi) begin
            r = OUT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            r = OUT_MIN[OUT_W-1:0];
        end
    end

`ifdef ACT_STATS_EN
    assign zero_flag = neg && (mode == ACT_RELU || mode == ACT_CLIP);
    assign sat_flag  = (mode == ACT_CLIP && !neg && (x > clip_max)) || sat_hi || sat_lo;
`endif

endmodule

// File: rtl/activation_unit.sv
// Multi-lane activation + requantisation stage, 2-stage valid/ready pipeline
// with a global stall (no skid buffer).
// Optional feature macro: ACT_STATS_EN (zero/sat statistics counters).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   mode       activation select, sampled with each accepted beat
//   clip_max   clipped-ReLU bound, sampled with each accepted beat
//   in_valid / in_ready / in_data    upstream handshake, LANES x DATA_W
//   out_valid / out_ready / out_data downstream handshake, LANES x OUT_W
//   stats_clr  clear counters (ACT_STATS_EN)
//   zero_cnt   lanes forced from negative to zero (ACT_STATS_EN)
//   sat_cnt    lanes clipped or saturated (ACT_STATS_EN)
module activation_unit
    import npu_act_pkg::*;
#(
    parameter int unsigned DATA_W      = 22,
    parameter int unsigned OUT_W       = 22,
    parameter int unsigned LANES       = 1,
    parameter int unsigned SHIFT       = 0,
    parameter int unsigned LEAKY_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         clip_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    out_data
`ifdef ACT_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [ACT_CNT_W-1:0]      zero_cnt,
    output logic [ACT_CNT_W-1:0]      sat_cnt
`endif
);

    logic                     en;
    logic                     s1_valid;
    logic [LANES*DATA_W-1:0]  s1_data;
    act_mode_t                s1_mode;
    logic [DATA_W-1:0]        s1_clip;
    logic [LANES*OUT_W-1:0]   lane_r;

    // Whole pipeline advances together; upstream sees the same enable.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage 1: capture beat together with its mode and clip bound.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= ACT_IDENT;
            s1_clip  <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
                s1_mode <= act_mode_t'(mode);
                s1_clip <= clip_max;
            end
        end
    end

`ifdef ACT_STATS_EN
    logic [LANES-1:0] zero_flag;
    logic [LANES-1:0] sat_flag;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        act_lane #(
            .DATA_W      (DATA_W),
            .OUT_W       (OUT_W),
            .SHIFT       (SHIFT),
            .LEAKY_SHIFT (LEAKY_SHIFT)
        ) u_lane (
            .x         (s1_data[g*DATA_W +: DATA_W]),
            .mode      (s1_mode),
            .clip_max  (s1_clip),
            .r         (lane_r[g*OUT_W +: OUT_W])
`ifdef ACT_STATS_EN
            ,
            .zero_flag (zero_flag[g]),
            .sat_flag  (sat_flag[g])
`endif
        );
    end

    // Stage 2: output register; data only changes when a real beat lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= lane_r;
            end
        end
    end

`ifdef ACT_STATS_EN
    logic [ACT_CNT_W-1:0] zero_inc;
    logic [ACT_CNT_W-1:0] sat_inc;

    // Per-beat count of qualifying lanes.
    always_comb begin
        zero_inc = '0;
        sat_inc  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            zero_inc = zero_inc + ACT_CNT_W'(zero_flag[i]);
            sat_inc  = sat_inc + ACT_CNT_W'(sat_flag[i]);
        end
    end

    // Counters follow stage-2 capture; clear takes priority.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            zero_cnt <= '0;
            sat_cnt  <= '0;
        end else if (en && s1_valid) begin
            zero_cnt <= cnt_sat_add(zero_cnt, zero_inc);
            sat_cnt  <= cnt_sat_add(sat_cnt, sat_inc);
        end
    end
`endif

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench for activation_unit: three instances (default, OUT_W=8
// with SHIFT=4, and LANES=4) driven from vector tables and short sequences.
module tb_activation_unit;

    localparam int M_IDENT = 0;
    localparam int M_RELU  = 1;
    localparam int M_LEAKY = 2;
    localparam int M_CLIP  = 3;

    typedef struct {
        logic [1:0]  mode;
        logic [21:0] clip;
        logic [21:0] x;
        logic [21:0] ea;
        logic [7:0]  eb;
    } vec_t;

    typedef struct {
        logic [87:0] d;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic mon_en = 1'b0;
    int   c_seen = 0;

    // Instances a and b share every input.
    logic [1:0]  mode_ab;
    logic [21:0] clip_ab;
    logic        iv_ab;
    logic [21:0] id_ab;
    logic        ordy_ab;
    logic        ir_a, ir_b, ov_a, ov_b;
    logic [21:0] od_a;
    logic [7:0]  od_b;

    logic [1:0]  mode_c;
    logic [21:0] clip_c;
    logic        iv_c;
    logic [87:0] id_c;
    logic        ordy_c;
    logic        ir_c, ov_c;
    logic [87:0] od_c;

`ifdef ACT_STATS_EN
    logic        clr_ab, clr_c;
    logic [15:0] zc_a, sc_a, zc_b, sc_b, zc_c, sc_c;
`endif

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t ma, mb, mc;
    vec_t tbl[26];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    activation_unit u_a (
        .clk(clk), .rst(rst), .mode(mode_ab), .clip_max(clip_ab),
        .in_valid(iv_ab), .in_ready(ir_a), .in_data(id_ab),
        .out_valid(ov_a), .out_ready(ordy_ab), .out_data(od_a)
`ifdef ACT_STATS_EN
        , .stats_clr(clr_ab), .zero_cnt(zc_a), .sat_cnt(sc_a)
`endif
    );

    activation_unit #(.OUT_W(8), .SHIFT(4)) u_b (
        .clk(clk), .rst(rst), .mode(mode_ab), .clip_max(clip_ab),
        .in_valid(iv_ab), .in_ready(ir_b), .in_data(id_ab),
        .out_valid(ov_b), .out_ready(ordy_ab), .out_data(od_b)
`ifdef ACT_STATS_EN
        , .stats_clr(clr_ab), .zero_cnt(zc_b), .sat_cnt(sc_b)
`endif
    );

    activation_unit #(.LANES(4)) u_c (
        .clk(clk), .rst(rst), .mode(mode_c), .clip_max(clip_c),
        .in_valid(iv_c), .in_ready(ir_c), .in_data(id_c),
        .out_valid(ov_c), .out_ready(ordy_c), .out_data(od_c)
`ifdef ACT_STATS_EN
        , .stats_clr(clr_c), .zero_cnt(zc_c), .sat_cnt(sc_c)
`endif
    );

    task automatic check(input string nm, input logic [87:0] act, input logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int m, input int c, input int x, input int ea, input int eb);
        vec_t v;
        v.mode = 2'(m);
        v.clip = 22'(c);
        v.x    = 22'(x);
        v.ea   = 22'(ea);
        v.eb   = 8'(eb);
        return v;
    endfunction

    // LANES=4 beat k: lane i = (k+1)*100 + 10*i, lane 1 negated; ReLU zeroes lane 1.
    function automatic logic [87:0] cbeat(input int k, input bit relu);
        logic [87:0] d;
        int v;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            v = (k + 1) * 100 + 10 * i;
            if (i == 1) v = relu ? 0 : -v;
            d[i*22 +: 22] = 22'(v);
        end
        return d;
    endfunction

    // Present one vector to a/b, hold until accepted, queue expectations.
    task automatic drive_ab(input vec_t v);
        int   waitc;
        exp_t e;
        waitc   = 0;
        mode_ab = v.mode;
        clip_ab = v.clip;
        id_ab   = v.x;
        iv_ab   = 1'b1;
        @(negedge clk);
        while (!(ir_a && ir_b) && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 20) begin
            checks++;
            errors++;
            $display("FAIL ab_accept_timeout: in_ready stayed low for %0d cycles", waitc);
        end else begin
            e.cyc = cyc;
            e.d   = 88'(v.ea);
            qa.push_back(e);
            e.d   = 88'(v.eb);
            qb.push_back(e);
        end
        @(posedge clk);
        #1;
        iv_ab = 1'b0;
    endtask

    // Output monitors: order, value and (a/b) fixed 2-cycle latency.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ov_a && ordy_ab) begin
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_extra_beat: got 0x%0h with nothing expected", od_a);
                end else begin
                    ma = qa.pop_front();
                    check("a_data", 88'(od_a), ma.d);
                    check("a_latency", 88'(cyc - ma.cyc), 88'd2);
                end
            end
            if (ov_b && ordy_ab) begin
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_extra_beat: got 0x%0h with nothing expected", od_b);
                end else begin
                    mb = qb.pop_front();
                    check("b_data", 88'(od_b), mb.d);
                    check("b_latency", 88'(cyc - mb.cyc), 88'd2);
                end
            end
            if (ov_c && ordy_c) begin
                c_seen++;
                if (qc.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL c_extra_beat: got 0x%0h with nothing expected", od_c);
                end else begin
                    mc = qc.pop_front();
                    check("c_data", od_c, mc.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        exp_t e;

        // mode, clip_max, x, expected a (22b, SHIFT 0), expected b (8b, SHIFT 4)
        tbl[0]  = mk(M_RELU,  0,        -5,       0,        0);
        tbl[1]  = mk(M_RELU,  0,        100,      100,      6);
        tbl[2]  = mk(M_RELU,  0,        0,        0,        0);
        tbl[3]  = mk(M_LEAKY, 0,        -16,      -2,       0);
        tbl[4]  = mk(M_LEAKY, 0,        -5,       -1,       0);
        tbl[5]  = mk(M_LEAKY, 0,        40,       40,       3);
        tbl[6]  = mk(M_CLIP,  6,        9,        6,        0);
        tbl[7]  = mk(M_CLIP,  6,        -3,       0,        0);
        tbl[8]  = mk(M_CLIP,  6,        4,        4,        0);
        tbl[9]  = mk(M_IDENT, 0,        2047,     2047,     127);
        tbl[10] = mk(M_IDENT, 0,        24,       24,       2);
        tbl[11] = mk(M_IDENT, 0,        -40,      -40,      -2);
        tbl[12] = mk(M_IDENT, 0,        -2097152, -2097152, -128);
        tbl[13] = mk(M_IDENT, 0,        2097151,  2097151,  127);
        tbl[14] = mk(M_CLIP,  -7,       5,        0,        0);
        tbl[15] = mk(M_LEAKY, 0,        -1,       -1,       0);
        tbl[16] = mk(M_IDENT, 0,        -9,       -9,       -1);
        tbl[17] = mk(M_IDENT, 0,        -8,       -8,       0);
        tbl[18] = mk(M_IDENT, 0,        7,        7,        0);
        tbl[19] = mk(M_IDENT, 0,        8,        8,        1);
        tbl[20] = mk(M_RELU,  0,        -2097152, 0,        0);
        tbl[21] = mk(M_CLIP,  2097151,  2097151,  2097151,  127);
        // Extra vectors for the statistics sequences.
        tbl[22] = mk(M_RELU,  0,        -1,       0,        0);
        tbl[23] = mk(M_CLIP,  6,        9,        6,        0);
        tbl[24] = mk(M_CLIP,  6,        -3,       0,        0);
        tbl[25] = mk(M_CLIP,  6,        4,        4,        0);

        rst = 1'b1;
        mode_ab = '0; clip_ab = '0; iv_ab = 1'b0; id_ab = '0; ordy_ab = 1'b1;
        mode_c = '0; clip_c = '0; iv_c = 1'b0; id_c = '0; ordy_c = 1'b1;
`ifdef ACT_STATS_EN
        clr_ab = 1'b0; clr_c = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, first cycle after reset.
        @(negedge clk);
        check("rst_out_valid_a", 88'(ov_a), 88'd0);
        check("rst_out_data_a", 88'(od_a), 88'd0);
        check("rst_in_ready_a", 88'(ir_a), 88'd1);
        check("rst_out_valid_b", 88'(ov_b), 88'd0);
        check("rst_out_valid_c", 88'(ov_c), 88'd0);
        check("rst_out_data_c", od_c, 88'd0);
        check("rst_in_ready_c", 88'(ir_c), 88'd1);
`ifdef ACT_STATS_EN
        check("rst_zero_cnt_a", 88'(zc_a), 88'd0);
        check("rst_sat_cnt_a", 88'(sc_a), 88'd0);
`endif
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back vector stream, mode changing beat to beat.
        for (int i = 0; i < 22; i++) drive_ab(tbl[i]);
        repeat (4) @(posedge clk);
        #1;
        check("ab_drain_a", 88'(qa.size()), 88'd0);
        check("ab_drain_b", 88'(qb.size()), 88'd0);

`ifdef ACT_STATS_EN
        check("tbl_zero_cnt_a", 88'(zc_a), 88'd3);
        check("tbl_sat_cnt_a", 88'(sc_a), 88'd2);
        check("tbl_zero_cnt_b", 88'(zc_b), 88'd3);
        check("tbl_sat_cnt_b", 88'(sc_b), 88'd6);
        // Clear lands on the same edge that captures a qualifying beat.
        drive_ab(tbl[22]);
        clr_ab = 1'b1;
        @(posedge clk);
        #1;
        clr_ab = 1'b0;
        @(negedge clk);
        check("clr_wins_zero_a", 88'(zc_a), 88'd0);
        check("clr_wins_sat_a", 88'(sc_a), 88'd0);
        @(posedge clk);
        #1;
        for (int i = 23; i < 26; i++) drive_ab(tbl[i]);
        repeat (4) @(posedge clk);
        #1;
        check("clip_zero_cnt_a", 88'(zc_a), 88'd1);
        check("clip_sat_cnt_a", 88'(sc_a), 88'd1);
        check("clip_zero_cnt_b", 88'(zc_b), 88'd1);
        check("clip_sat_cnt_b", 88'(sc_b), 88'd1);
`endif

        // LANES=4: 6 beats, out_ready low for cycles 3..7.
        mode_c = 2'(M_RELU);
        k = 0;
        for (int t = 0; t < 20; t++) begin
            ordy_c = !(t >= 3 && t <= 7);
            iv_c   = (k < 6);
            id_c   = cbeat(k, 1'b0);
            @(negedge clk);
            if (t < 13) check("c_in_ready", 88'(ir_c), 88'(!(t >= 3 && t <= 7)));
            if (t >= 3 && t <= 7) begin
                check("c_stall_valid", 88'(ov_c), 88'd1);
                check("c_stall_hold", od_c, cbeat(1, 1'b1));
            end
            if (iv_c && ir_c) begin
                e.d   = cbeat(k, 1'b1);
                e.cyc = cyc;
                qc.push_back(e);
                k++;
            end
            @(posedge clk);
            #1;
        end
        iv_c = 1'b0;
        check("c_beats_out", 88'(c_seen), 88'd6);
        check("c_drain", 88'(qc.size()), 88'd0);
`ifdef ACT_STATS_EN
        check("c_zero_cnt", 88'(zc_c), 88'd6);
        check("c_sat_cnt", 88'(sc_c), 88'd0);
`endif

        // Reset with two beats in flight.
        mon_en = 1'b0;
        mode_ab = 2'(M_RELU);
        clip_ab = '0;
        id_ab   = 22'(50);
        iv_ab   = 1'b1;
        @(posedge clk);
        #1;
        id_ab = 22'(-3);
        @(posedge clk);
        #1;
        iv_ab = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check("inflight_valid_a", 88'(ov_a), 88'd1);
        check("inflight_data_a", 88'(od_a), 88'd50);
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        qb.delete();
        @(negedge clk);
        check("midrst_out_valid_a", 88'(ov_a), 88'd0);
        check("midrst_out_valid_b", 88'(ov_b), 88'd0);
        check("midrst_in_ready_a", 88'(ir_a), 88'd1);
`ifdef ACT_STATS_EN
        check("midrst_zero_cnt_a", 88'(zc_a), 88'd0);
        check("midrst_sat_cnt_a", 88'(sc_a), 88'd0);
        check("midrst_zero_cnt_c", 88'(zc_c), 88'd0);
`endif
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        drive_ab(mk(M_IDENT, 0, 33, 33, 2));
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_drain_a", 88'(qa.size()), 88'd0);
        check("post_rst_drain_b", 88'(qb.size()), 88'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
